// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order result buffer that drains one entry per cycle
// onto the register file write port. It also reports pending writes so that
// operand fetch can stall reads of stale values.
module reg_writeback_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [ADDR_W-1:0]          res_dir,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       wb_en,
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          dir_WR,
  output logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          chk_dirA,
  input  logic [ADDR_W-1:0]          chk_dirB,
  output logic                       pendA,
  output logic                       pendB,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dir_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle,
  // which keeps res_ready a function of the registered count alone.
  assign res_ready = (count != CNT_W'(DEPTH));
  assign push      = res_valid && res_ready;
  assign pop       = wb_en && (count != '0);
  assign occupancy = count;

  // FIFO storage, pointers, count and the registered write-port stage.
  // Push and pop never target the same slot: that would need a full or an
  // empty FIFO, and neither allows the corresponding operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dir_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
      valid     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      reg_write <= 1'b0;
      dir_WR    <= '0;
      wr_data   <= '0;
    end else begin
      if (push) begin
        dir_mem[wr_ptr]  <= res_dir;
        data_mem[wr_ptr] <= res_data;
        valid[wr_ptr]    <= 1'b1;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        reg_write     <= 1'b1;
        dir_WR        <= dir_mem[rd_ptr];
        wr_data       <= data_mem[rd_ptr];
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end else begin
        reg_write <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Hazard scoreboard: a register is pending while it sits in the FIFO or in
  // the output stage, since the register file commits on the falling edge.
  always_comb begin
    pendA = reg_write && (dir_WR == chk_dirA);
    pendB = reg_write && (dir_WR == chk_dirB);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (dir_mem[i] == chk_dirA)) pendA = 1'b1;
      if (valid[i] && (dir_mem[i] == chk_dirB)) pendB = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a falling-edge register file model.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_dir;
  logic [31:0] res_data;
  logic        wb_en;
  logic        reg_write;
  logic [3:0]  dir_WR;
  logic [31:0] wr_data;
  logic [3:0]  chk_dirA;
  logic [3:0]  chk_dirB;
  logic        pendA;
  logic        pendB;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;
  logic [31:0] rf [16];

  always #5 clk = ~clk;

  reg_writeback_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_dir(res_dir), .res_data(res_data), .wb_en(wb_en),
    .reg_write(reg_write), .dir_WR(dir_WR), .wr_data(wr_data),
    .chk_dirA(chk_dirA), .chk_dirB(chk_dirB), .pendA(pendA), .pendB(pendB),
    .occupancy(occupancy)
  );

  // Register file commits on the falling edge.
  always @(negedge clk) if (reg_write) rf[dir_WR] = wr_data;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; res_valid = 1'b0; res_dir = '0; res_data = '0;
    wb_en = 1'b1; chk_dirA = '0; chk_dirB = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    #12;
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL rst_reg_write got=%0b exp=0", reg_write); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (dir_WR !== 4'd0 || wr_data !== 32'd0) begin failures++; $display("FAIL rst_out got=%0h/%0h exp=0/0", dir_WR, wr_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", res_ready); end
    checks++; if (pendA !== 1'b0 || pendB !== 1'b0) begin failures++; $display("FAIL rst_pend got=%0b%0b exp=00", pendA, pendB); end
  endtask

  task automatic test_single;
    @(negedge clk); res_valid = 1'b1; res_dir = 4'd3; res_data = 32'hDEADBEEF;
    tick;
    checks++; if (occupancy !== 3'd1 || reg_write !== 1'b0) begin failures++; $display("FAIL single_push occ=%0d rw=%0b exp occ=1 rw=0", occupancy, reg_write); end
    @(negedge clk); res_valid = 1'b0;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd3 || wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_strobe got=%0b/%0h/%0h exp=1/3/deadbeef", reg_write, dir_WR, wr_data); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL single_occ got=%0d exp=0", occupancy); end
    tick;
    checks++; if (reg_write !== 1'b0 || dir_WR !== 4'd3 || wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%0b/%0h/%0h exp=0/3/deadbeef", reg_write, dir_WR, wr_data); end
    checks++; if (rf[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rf got=%0h exp=deadbeef", rf[3]); end
  endtask

  task automatic test_full;
    @(negedge clk); wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_valid = 1'b1; res_dir = 4'(i + 1); res_data = 32'h100 + 32'(i);
      #1;
      checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%0b exp=1", i, res_ready); end
      tick;
      checks++; if (occupancy !== 3'(i + 1)) begin failures++; $display("FAIL full_occ%0d got=%0d exp=%0d", i, occupancy, i + 1); end
    end
    @(negedge clk); res_dir = 4'd5; res_data = 32'h104;
    checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL full_notready got=%0b exp=0", res_ready); end
    tick;
    checks++; if (occupancy !== 3'd4 || reg_write !== 1'b0) begin failures++; $display("FAIL full_held occ=%0d rw=%0b exp occ=4 rw=0", occupancy, reg_write); end
    @(negedge clk); wb_en = 1'b1;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd1 || wr_data !== 32'h100 || occupancy !== 3'd3) begin failures++; $display("FAIL full_pop0 got=%0b/%0h/%0h occ=%0d exp=1/1/100 occ=3", reg_write, dir_WR, wr_data, occupancy); end
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd2 || wr_data !== 32'h101 || occupancy !== 3'd3) begin failures++; $display("FAIL full_pop1 got=%0b/%0h/%0h occ=%0d exp=1/2/101 occ=3", reg_write, dir_WR, wr_data, occupancy); end
    @(negedge clk); res_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      tick;
      checks++; if (reg_write !== 1'b1 || dir_WR !== 4'(k + 1) || wr_data !== 32'h100 + 32'(k) || occupancy !== 3'(4 - k)) begin
        failures++; $display("FAIL full_pop%0d got=%0b/%0h/%0h occ=%0d exp=1/%0h/%0h occ=%0d", k, reg_write, dir_WR, wr_data, occupancy, k + 1, 32'h100 + 32'(k), 4 - k);
      end
    end
    tick;
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL full_done got=%0b exp=0", reg_write); end
  endtask

  task automatic test_pending;
    @(negedge clk); wb_en = 1'b0; res_valid = 1'b1; res_dir = 4'd7; res_data = 32'h77;
    tick;
    @(negedge clk); res_valid = 1'b0; chk_dirA = 4'd7; chk_dirB = 4'd2; #1;
    checks++; if (pendA !== 1'b1 || pendB !== 1'b0) begin failures++; $display("FAIL pend_queued got=%0b%0b exp=10", pendA, pendB); end
    wb_en = 1'b1;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd7 || pendA !== 1'b1) begin failures++; $display("FAIL pend_strobe rw=%0b dir=%0h pendA=%0b exp 1/7/1", reg_write, dir_WR, pendA); end
    tick;
    checks++; if (reg_write !== 1'b0 || pendA !== 1'b0 || pendB !== 1'b0) begin failures++; $display("FAIL pend_clear rw=%0b pend=%0b%0b exp 0/00", reg_write, pendA, pendB); end
  endtask

  task automatic test_same_reg;
    @(negedge clk); res_valid = 1'b1; res_dir = 4'd1; res_data = 32'h11;
    tick;
    @(negedge clk); res_data = 32'h22;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd1 || wr_data !== 32'h11 || occupancy !== 3'd1) begin failures++; $display("FAIL same_first got=%0b/%0h/%0h occ=%0d exp=1/1/11 occ=1", reg_write, dir_WR, wr_data, occupancy); end
    @(negedge clk); res_valid = 1'b0;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd1 || wr_data !== 32'h22 || occupancy !== 3'd0) begin failures++; $display("FAIL same_second got=%0b/%0h/%0h occ=%0d exp=1/1/22 occ=0", reg_write, dir_WR, wr_data, occupancy); end
    checks++; if (rf[1] !== 32'h11) begin failures++; $display("FAIL same_rf_mid got=%0h exp=11", rf[1]); end
    @(negedge clk); #1;
    checks++; if (rf[1] !== 32'h22) begin failures++; $display("FAIL same_rf_final got=%0h exp=22", rf[1]); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); wb_en = 1'b0; res_valid = 1'b1; res_dir = 4'd0; res_data = 32'hA0;
    tick;
    @(negedge clk); res_dir = 4'd1; res_data = 32'hA1;
    tick;
    checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL b2b_fill got=%0d exp=2", occupancy); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); wb_en = 1'b1; res_dir = 4'(k + 2); res_data = 32'hA2 + 32'(k);
      tick;
      checks++; if (reg_write !== 1'b1 || dir_WR !== 4'(k) || wr_data !== 32'hA0 + 32'(k) || occupancy !== 3'd2) begin
        failures++; $display("FAIL b2b_step%0d got=%0b/%0h/%0h occ=%0d exp=1/%0h/%0h occ=2", k, reg_write, dir_WR, wr_data, occupancy, k, 32'hA0 + 32'(k));
      end
    end
    @(negedge clk); res_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      tick;
      checks++; if (reg_write !== 1'b1 || dir_WR !== 4'(k) || wr_data !== 32'hA0 + 32'(k) || occupancy !== 3'(11 - k)) begin
        failures++; $display("FAIL b2b_drain%0d got=%0b/%0h/%0h occ=%0d exp=1/%0h/%0h occ=%0d", k, reg_write, dir_WR, wr_data, occupancy, k, 32'hA0 + 32'(k), 11 - k);
      end
    end
    tick;
    checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", reg_write); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); res_valid = 1'b1; res_dir = 4'(8 + i); res_data = 32'hC0 + 32'(i);
      tick;
    end
    @(negedge clk); res_valid = 1'b0; wb_en = 1'b1; chk_dirA = 4'd10; chk_dirB = 4'd8;
    tick;
    checks++; if (reg_write !== 1'b1 || dir_WR !== 4'd8 || occupancy !== 3'd3 || pendA !== 1'b1 || pendB !== 1'b1) begin
      failures++; $display("FAIL arst_pre rw=%0b dir=%0h occ=%0d pend=%0b%0b exp 1/8/3/11", reg_write, dir_WR, occupancy, pendA, pendB);
    end
    #2; rst_n = 1'b0; #1;
    checks++; if (reg_write !== 1'b0 || occupancy !== 3'd0 || pendA !== 1'b0 || pendB !== 1'b0) begin
      failures++; $display("FAIL arst_now rw=%0b occ=%0d pend=%0b%0b exp 0/0/00", reg_write, occupancy, pendA, pendB);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (reg_write !== 1'b0 || occupancy !== 3'd0 || res_ready !== 1'b1 || dir_WR !== 4'd0) begin
        failures++; $display("FAIL arst_after%0d rw=%0b occ=%0d rdy=%0b dir=%0h exp 0/0/1/0", k, reg_write, occupancy, res_ready, dir_WR);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_full;
    test_pending;
    test_same_reg;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
